// File: rtl/alu_sequencer_if.sv
// Request / ALU / response signal bundle for alu_sequencer.
// The sequencer uses the slave view; the environment (requester, ALU, consumer) uses master.
interface alu_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 3
);
   logic                  req_valid;
   logic                  req_ready;
   logic [OP_WIDTH-1:0]   req_op;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic [DATA_WIDTH-1:0] alu_data1;
   logic [DATA_WIDTH-1:0] alu_data2;
   logic [OP_WIDTH-1:0]   alu_op;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp_err;
   logic                  resp_ovf;

   modport master (
      output req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      input  req_ready, alu_data1, alu_data2, alu_op, resp_valid, resp_data, resp_err, resp_ovf
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      output req_ready, alu_data1, alu_data2, alu_op, resp_valid, resp_data, resp_err, resp_ovf
   );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one request at a time to an external combinational ALU and returns the result.
// MUL is performed as repeated ADDs through the same ALU, with a sticky wrap flag.
module alu_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 3,
   parameter bit MUL_EN     = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   alu_sequencer_if.slave bus
);
   localparam logic [OP_WIDTH-1:0] op_add = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] op_or  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] op_mul = OP_WIDTH'(4);

   typedef enum logic [1:0] {s_idle, s_exec, s_mul, s_done} state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] a_reg, a_next;
   logic [DATA_WIDTH-1:0] cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0] d1_reg, d1_next;
   logic [DATA_WIDTH-1:0] d2_reg, d2_next;
   logic [OP_WIDTH-1:0]   aop_reg, aop_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic                  err_reg, err_next;
   logic                  ovf_reg, ovf_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= s_idle;
         a_reg     <= '0;
         cnt_reg   <= '0;
         d1_reg    <= '0;
         d2_reg    <= '0;
         aop_reg   <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         cnt_reg   <= cnt_next;
         d1_reg    <= d1_next;
         d2_reg    <= d2_next;
         aop_reg   <= aop_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
         ovf_reg   <= ovf_next;
      end
   end

   // ALU lines default to 0/0/000; only the EXEC and MUL cycles load them.
   // During MUL, d1_reg is the running accumulator.
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      cnt_next   = cnt_reg;
      d1_next    = '0;
      d2_next    = '0;
      aop_next   = '0;
      data_next  = data_reg;
      err_next   = err_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         s_idle: begin
            if (bus.req_valid) begin
               a_next   = bus.req_a;
               err_next = 1'b0;
               ovf_next = 1'b0;
               if (bus.req_op <= op_or) begin
                  state_next = s_exec;
                  d1_next    = bus.req_a;
                  d2_next    = bus.req_b;
                  aop_next   = bus.req_op;
               end else if (MUL_EN && bus.req_op == op_mul) begin
                  if (bus.req_b != '0) begin
                     state_next = s_mul;
                     cnt_next   = bus.req_b;
                     d2_next    = bus.req_a;
                     aop_next   = op_add;
                  end else begin
                     state_next = s_done;
                     data_next  = '0;
                  end
               end else begin
                  state_next = s_done;
                  data_next  = '0;
                  err_next   = 1'b1;
               end
            end
         end
         s_exec: begin
            data_next  = bus.alu_result;
            state_next = s_done;
         end
         s_mul: begin
            // A sum smaller than the accumulator means this addition carried out.
            if (bus.alu_result < d1_reg)
               ovf_next = 1'b1;
            cnt_next = cnt_reg - DATA_WIDTH'(1);
            if (cnt_reg == DATA_WIDTH'(1)) begin
               data_next  = bus.alu_result;
               state_next = s_done;
            end else begin
               d1_next  = bus.alu_result;
               d2_next  = a_reg;
               aop_next = op_add;
            end
         end
         s_done: begin
            if (bus.resp_ready) begin
               state_next = s_idle;
               err_next   = 1'b0;
               ovf_next   = 1'b0;
            end
         end
         default: state_next = s_idle;
      endcase
   end

   assign bus.req_ready  = (state_reg == s_idle);
   assign bus.resp_valid = (state_reg == s_done);
   assign bus.alu_data1  = d1_reg;
   assign bus.alu_data2  = d2_reg;
   assign bus.alu_op     = aop_reg;
   assign bus.resp_data  = data_reg;
   assign bus.resp_err   = err_reg;
   assign bus.resp_ovf   = ovf_reg;
endmodule
